alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one combinational 32-bit ALU (3-bit opcode, operands A/B, overflow/carry flags) between two requesters.
- Round-robin arbitration. Accepted operands/opcode are registered and driven to the ALU for ALU_LAT cycles, then the result is captured.
- The response is returned through a valid/ready handshake, tagged with the requester id.
- Sits between the control/sequencing logic and the ALU instance in the datapath.

Parameters:
- WIDTH, 32, operand/result width
- OPW, 3, opcode width
- ALU_LAT, 1, cycles operands are held on the ALU before capture; legal >=1; 0 behaves as 1

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_opcode  in  OPW  requester 0 opcode
- req0_a  in  WIDTH  requester 0 operand A
- req0_b  in  WIDTH  requester 0 operand B
- req1_valid, req1_ready, req1_opcode, req1_a, req1_b: as requester 0, for requester 1
- alu_opcode  out  OPW  registered opcode to ALU
- alu_a  out  WIDTH  registered operand A to ALU
- alu_b  out  WIDTH  registered operand B to ALU
- alu_result  in  WIDTH  ALU result
- alu_overflow  in  1  ALU overflow flag
- alu_carry  in  1  ALU carry flag
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester that issued the operation
- rsp_result  out  WIDTH  captured result
- rsp_overflow  out  1  captured overflow
- rsp_carry  out  1  captured carry
- rsp_zero  out  1  captured result == 0

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, last_grant=1, wait counter=0.
  - alu_opcode/alu_a/alu_b=0.
  - All rsp_* = 0. req0_ready = req1_ready = 0.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Winner selection: if only one reqN_valid, that requester wins. If both, the requester != last_grant wins; after reset, requester 0 wins the first tie.
  - reqN_ready=1 combinationally for the winner only; both ready low if no valid.
  - On handshake: latch opcode/a/b into the alu_* registers, latch id, last_grant=id, counter=ALU_LAT-1, go to WAIT.
- WAIT:
  - alu_* held stable. Counter decrements each cycle.
  - At the cycle with counter==0:
    - capture alu_result into rsp_result;
    - rsp_zero = (alu_result == 0), computed locally, not taken from the ALU;
    - rsp_overflow/rsp_carry = ALU flags only for opcodes 3'b010, 3'b100, 3'b111, otherwise forced 0;
    - rsp_id = latched id; rsp_valid=1; go to RESP.
- Latency: handshake edge to rsp_valid high = ALU_LAT cycles.
- RESP:
  - All rsp_* held stable while rsp_valid && !rsp_ready.
  - On rsp_ready: rsp_valid=0 next cycle, go to IDLE.
  - No request accepted in WAIT or RESP (req*_ready=0).
  - Peak throughput: one op per ALU_LAT+2 cycles.
- Requester inputs are sampled only at the handshake; later changes are ignored.
- alu_* retain the last operation's values while idle; there is no toggling when idle.
- Reset asserted mid-WAIT/RESP: the transaction is dropped, no response is produced, and all reset values apply immediately.
- Starvation bound: with both requesters continuously valid, grants strictly alternate.

Optional Feature:
- Macro ALU_ARB_STATS_EN.
- Defined:
  - adds outputs grant_cnt0, grant_cnt1 (16 bits each);
  - each increments on its requester's handshake and saturates at 16'hFFFF;
  - reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Only req0 valid, opcode 3'b100, a=5, b=5, ALU_LAT=1, rsp_ready=1 -> req0_ready high in IDLE; alu_a=5/alu_b=5 next cycle; rsp_valid 1 cycle after handshake; rsp_result=0, rsp_zero=1, rsp_id=0.
- Both valid continuously for 6 ops -> rsp_id sequence 0,1,0,1,0,1; the non-granted ready is never high.
- Opcode 3'b011 (NOR) with ALU driving overflow=1, carry=1 -> rsp_overflow=0, rsp_carry=0. Opcode 3'b010 with a=32'h8000_0000 -> rsp_carry follows ALU (1).
- rsp_ready held low for 5 cycles while req1 valid -> rsp_* stable, req1_ready=0 throughout; accept on cycle 6, then req1 granted in IDLE.
- ALU_LAT=3, single op -> alu_* stable 3 cycles; rsp_valid exactly 3 cycles after handshake.
- rst_n pulsed low during WAIT -> rsp_valid stays 0, alu_*=0, next tie grants requester 0. With ALU_ARB_STATS_EN: grant_cnt reads 0 after reset and increments per grant.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Optional grant counters: define ALU_ARB_STATS_EN.
module alu_arbiter #(
  parameter int WIDTH   = 32,
  parameter int OPW     = 3,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_opcode,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_opcode,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [OPW-1:0]   alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_overflow,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_overflow,
  output logic             rsp_carry,
  output logic             rsp_zero
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]      grant_cnt0,
  output logic [15:0]      grant_cnt1
`endif
);

  localparam int LAT = (ALU_LAT < 1) ? 1 : ALU_LAT;
  localparam int CW  = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] CINIT = CW'(LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t        state;
  logic          last_grant;
  logic          id;
  logic [CW-1:0] cnt;
  logic          gnt0;
  logic          gnt1;
  logic          hs;
  logic          flag_en;

  // Tie goes to the requester that was not granted last.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE) begin
      unique case (1'b1)
        req0_valid && req1_valid: begin
          gnt0 = last_grant;
          gnt1 = !last_grant;
        end
        req0_valid && !req1_valid: gnt0 = 1'b1;
        !req0_valid && req1_valid: gnt1 = 1'b1;
        default: ;
      endcase
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign hs         = gnt0 | gnt1;

  // Only add, subtract and add-with-carry report flags.
  assign flag_en = (alu_opcode == OPW'(3'b010))
                 | (alu_opcode == OPW'(3'b100))
                 | (alu_opcode == OPW'(3'b111));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      id           <= 1'b0;
      cnt          <= '0;
      alu_opcode   <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
      rsp_carry    <= 1'b0;
      rsp_zero     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (hs) begin
            alu_opcode <= gnt1 ? req1_opcode : req0_opcode;
            alu_a      <= gnt1 ? req1_a : req0_a;
            alu_b      <= gnt1 ? req1_b : req0_b;
            id         <= gnt1;
            last_grant <= gnt1;
            cnt        <= CINIT;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            rsp_result   <= alu_result;
            rsp_zero     <= (alu_result == '0);
            rsp_overflow <= flag_en & alu_overflow;
            rsp_carry    <= flag_en & alu_carry;
            rsp_id       <= id;
            rsp_valid    <= 1'b1;
            state        <= RESP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (gnt0 && grant_cnt0 != 16'hFFFF)
        grant_cnt0 <= grant_cnt0 + 16'd1;
      if (gnt1 && grant_cnt1 != 16'hFFFF)
        grant_cnt1 <= grant_cnt1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table plus stall, alternation,
// mid-transaction reset and ALU_LAT=3 sequences.
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready;
  logic [2:0]  req0_opcode;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready;
  logic [2:0]  req1_opcode;
  logic [31:0] req1_a, req1_b;
  logic [2:0]  alu_opcode;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_overflow, alu_carry;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_overflow, rsp_carry, rsp_zero;

  logic        q0_valid, q0_ready, q1_valid, q1_ready;
  logic [2:0]  q0_opcode, q1_opcode, qalu_opcode;
  logic [31:0] q0_a, q0_b, q1_a, q1_b;
  logic [31:0] qalu_a, qalu_b, qalu_result;
  logic        qalu_overflow, qalu_carry;
  logic        qrsp_valid, qrsp_ready, qrsp_id;
  logic [31:0] qrsp_result;
  logic        qrsp_overflow, qrsp_carry, qrsp_zero;

`ifdef ALU_ARB_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1, qcnt0, qcnt1;
`endif

  int tests = 0;
  int fails = 0;

  alu_arbiter #(.WIDTH(32), .OPW(3), .ALU_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_opcode(req0_opcode), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_opcode(req1_opcode), .req1_a(req1_a), .req1_b(req1_b),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_overflow(alu_overflow),
    .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_overflow(rsp_overflow),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero)
`ifdef ALU_ARB_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  alu_arbiter #(.WIDTH(32), .OPW(3), .ALU_LAT(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(q0_valid), .req0_ready(q0_ready),
    .req0_opcode(q0_opcode), .req0_a(q0_a), .req0_b(q0_b),
    .req1_valid(q1_valid), .req1_ready(q1_ready),
    .req1_opcode(q1_opcode), .req1_a(q1_a), .req1_b(q1_b),
    .alu_opcode(qalu_opcode), .alu_a(qalu_a), .alu_b(qalu_b),
    .alu_result(qalu_result), .alu_overflow(qalu_overflow),
    .alu_carry(qalu_carry),
    .rsp_valid(qrsp_valid), .rsp_ready(qrsp_ready), .rsp_id(qrsp_id),
    .rsp_result(qrsp_result), .rsp_overflow(qrsp_overflow),
    .rsp_carry(qrsp_carry), .rsp_zero(qrsp_zero)
`ifdef ALU_ARB_STATS_EN
    , .grant_cnt0(qcnt0), .grant_cnt1(qcnt1)
`endif
  );

  // Reference ALU; flagless ops drive garbage flags (1/1).
  function automatic logic [33:0] alu_f(input logic [2:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic o, c;
    s = '0; r = '0; o = 1'b1; c = 1'b1;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0]; c = s[32];
        o = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'd3: r = ~(a | b);
      3'd4: begin
        r = a - b; c = (a < b);
        o = (a[31] != b[31]) && (r[31] != a[31]);
      end
      3'd5: r = a ^ b;
      3'd6: r = {31'b0, $signed(a) < $signed(b)};
      default: begin
        s = {1'b0, a} + {1'b0, b} + 33'd1;
        r = s[31:0]; c = s[32];
        o = (a[31] == b[31]) && (r[31] != a[31]);
      end
    endcase
    return {r, o, c};
  endfunction

  always_comb {alu_result, alu_overflow, alu_carry} =
    alu_f(alu_opcode, alu_a, alu_b);
  always_comb {qalu_result, qalu_overflow, qalu_carry} =
    alu_f(qalu_opcode, qalu_a, qalu_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        v0, v1;
    logic [2:0]  op0, op1;
    logic [31:0] a0, b0, a1, b1;
    logic        eid;
    logic [31:0] eres;
    logic        eovf, ecry, ezero;
  } vec_t;

  task automatic run_vec(input vec_t t, input int k);
    int n;
    @(negedge clk);
    req0_valid = t.v0; req0_opcode = t.op0;
    req0_a = t.a0; req0_b = t.b0;
    req1_valid = t.v1; req1_opcode = t.op1;
    req1_a = t.a1; req1_b = t.b1;
    #1;
    n = 0;
    while (!(req0_ready || req1_ready) && n < 8) begin
      @(negedge clk); #1; n++;
    end
    chk($sformatf("v%0d_grant_seen", k), 32'(n < 8), 32'd1);
    chk($sformatf("v%0d_dual_ready", k),
        32'(req0_ready & req1_ready), 32'd0);
    chk($sformatf("v%0d_grant_id", k), 32'(req1_ready), 32'(t.eid));
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk($sformatf("v%0d_alu_a", k), alu_a, t.eid ? t.a1 : t.a0);
    chk($sformatf("v%0d_alu_b", k), alu_b, t.eid ? t.b1 : t.b0);
    n = 0;
    while (!rsp_valid && n < 8) begin
      @(negedge clk); n++;
    end
    chk($sformatf("v%0d_latency", k), n, 32'd1);
    chk($sformatf("v%0d_rsp_id", k), 32'(rsp_id), 32'(t.eid));
    chk($sformatf("v%0d_result", k), rsp_result, t.eres);
    chk($sformatf("v%0d_ovf", k), 32'(rsp_overflow), 32'(t.eovf));
    chk($sformatf("v%0d_carry", k), 32'(rsp_carry), 32'(t.ecry));
    chk($sformatf("v%0d_zero", k), 32'(rsp_zero), 32'(t.ezero));
  endtask

  task automatic wait_ready(input string nm, input logic which);
    int n;
    #1;
    n = 0;
    while (!(which ? req1_ready : req0_ready) && n < 10) begin
      @(negedge clk); #1; n++;
    end
    chk(nm, 32'(n < 10), 32'd1);
  endtask

  task automatic wait_rsp(input string nm);
    int n;
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(negedge clk); n++;
    end
    chk(nm, 32'(n < 10), 32'd1);
  endtask

  vec_t vt[8];
  logic ids[6];

  initial begin
    int   n, got;
    logic bad;
    logic [31:0] res0;

    // Expected ids assume last_grant tracking from reset (initially 1).
    vt[0] = '{1, 0, 3'b100, 3'b000, 32'd5, 32'd5, 0, 0,
              0, 32'h0, 0, 0, 1};
    vt[1] = '{0, 1, 3'b000, 3'b011, 0, 0, 32'h0, 32'h0,
              1, 32'hFFFF_FFFF, 0, 0, 0};
    vt[2] = '{1, 1, 3'b010, 3'b000, 32'h8000_0000, 32'h8000_0000,
              32'h3, 32'h1, 0, 32'h0, 1, 1, 1};
    vt[3] = '{1, 1, 3'b001, 3'b010, 32'h1, 32'h2,
              32'h7FFF_FFFF, 32'h1, 1, 32'h8000_0000, 1, 0, 0};
    vt[4] = '{1, 1, 3'b100, 3'b000, 32'd3, 32'd5, 32'h9, 32'h9,
              0, 32'hFFFF_FFFE, 0, 1, 0};
    vt[5] = '{1, 1, 3'b000, 3'b111, 32'h4, 32'h4,
              32'hFFFF_FFFF, 32'h0, 1, 32'h0, 0, 1, 1};
    vt[6] = '{0, 1, 3'b000, 3'b101, 0, 0,
              32'hF0F0_F0F0, 32'h0F0F_0F0F, 1, 32'hFFFF_FFFF, 0, 0, 0};
    vt[7] = '{1, 1, 3'b110, 3'b001, 32'd1, 32'd2, 32'h5, 32'h6,
              0, 32'h1, 0, 0, 0};

    rst_n = 1'b0;
    req0_valid = 0; req0_opcode = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_opcode = 0; req1_a = 0; req1_b = 0;
    rsp_ready = 1'b1;
    q0_valid = 0; q0_opcode = 0; q0_a = 0; q0_b = 0;
    q1_valid = 0; q1_opcode = 0; q1_a = 0; q1_b = 0;
    qrsp_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_opcode", 32'(alu_opcode), 32'd0);
    chk("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
`ifdef ALU_ARB_STATS_EN
    chk("rst_cnt0", 32'(grant_cnt0), 32'd0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vt[i], i);

    // Response back-pressure while requester 1 waits.
    @(negedge clk);
    rsp_ready = 1'b0;
    req0_valid = 1; req0_opcode = 3'b000;
    req0_a = 32'hFF; req0_b = 32'h0F;
    wait_ready("stall_grant", 1'b0);
    @(negedge clk);
    req0_valid = 0;
    req1_valid = 1; req1_opcode = 3'b001; req1_a = 32'h1; req1_b = 32'h2;
    wait_rsp("stall_rsp_seen");
    res0 = rsp_result;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (!rsp_valid || rsp_result !== res0 || rsp_id !== 1'b0 ||
          req1_ready)
        bad = 1'b1;
      @(negedge clk);
    end
    chk("stall_stable", 32'(bad), 32'd0);
    chk("stall_result", res0, 32'h0F);
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    chk("stall_release_valid", 32'(rsp_valid), 32'd0);
    chk("stall_req1_ready", 32'(req1_ready), 32'd1);
    @(negedge clk);
    req1_valid = 0;
    wait_rsp("stall_r1_seen");
    chk("stall_r1_id", 32'(rsp_id), 32'd1);
    chk("stall_r1_result", rsp_result, 32'h3);

    // Both valid continuously: grants alternate starting with 0.
    @(negedge clk);
    req0_valid = 1; req0_opcode = 3'b000; req0_a = 1; req0_b = 1;
    req1_valid = 1; req1_opcode = 3'b001; req1_a = 2; req1_b = 2;
    got = 0; n = 0; bad = 1'b0;
    while (got < 6 && n < 60) begin
      @(negedge clk); #1; n++;
      if (req0_ready && req1_ready) bad = 1'b1;
      if (rsp_valid) begin
        ids[got] = rsp_id;
        got++;
      end
    end
    req0_valid = 0; req1_valid = 0;
    chk("alt_count", got, 32'd6);
    chk("alt_dual_ready", 32'(bad), 32'd0);
    for (int i = 0; i < 6; i++)
      chk($sformatf("alt_id%0d", i), 32'(ids[i]), 32'(i % 2));

    // Reset in WAIT drops the transaction.
    @(negedge clk);
    req0_valid = 1; req0_opcode = 3'b010; req0_a = 10; req0_b = 20;
    wait_ready("rstw_grant", 1'b0);
    @(negedge clk);
    req0_valid = 0;
    chk("rstw_alu_a_pre", alu_a, 32'd10);
    rst_n = 1'b0;
    #1;
    chk("rstw_alu_a", alu_a, 32'd0);
    chk("rstw_alu_b", alu_b, 32'd0);
    chk("rstw_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rsp_valid) bad = 1'b1;
    end
    chk("rstw_no_rsp", 32'(bad), 32'd0);
`ifdef ALU_ARB_STATS_EN
    chk("rstw_cnt0_zero", 32'(grant_cnt0), 32'd0);
`endif
    req0_valid = 1; req0_opcode = 3'b000; req0_a = 7; req0_b = 3;
    req1_valid = 1; req1_opcode = 3'b000; req1_a = 9; req1_b = 9;
    #1;
    chk("rstw_tie_r0", 32'(req0_ready), 32'd1);
    chk("rstw_tie_r1", 32'(req1_ready), 32'd0);
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
`ifdef ALU_ARB_STATS_EN
    chk("rstw_cnt0_one", 32'(grant_cnt0), 32'd1);
    chk("rstw_cnt1_zero", 32'(grant_cnt1), 32'd0);
`endif
    wait_rsp("rstw_rsp_seen");
    chk("rstw_result", rsp_result, 32'h3);

    // ALU_LAT=3 instance.
    @(negedge clk);
    q0_valid = 1; q0_opcode = 3'b010; q0_a = 1; q0_b = 2;
    #1;
    n = 0;
    while (!q0_ready && n < 10) begin
      @(negedge clk); #1; n++;
    end
    chk("lat3_grant", 32'(n < 10), 32'd1);
    @(negedge clk);
    q0_valid = 0;
    n = 0; bad = 1'b0;
    while (!qrsp_valid && n < 10) begin
      if (qalu_a !== 32'd1 || qalu_b !== 32'd2 || qalu_opcode !== 3'b010)
        bad = 1'b1;
      @(negedge clk); n++;
    end
    chk("lat3_latency", n, 32'd3);
    chk("lat3_alu_stable", 32'(bad), 32'd0);
    chk("lat3_result", qrsp_result, 32'd3);
    chk("lat3_id", 32'(qrsp_id), 32'd0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
